// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: one command in, one framebuffer write per pixel out.
// Optional framebuffer clipping is enabled by defining LRE_CLIP_EN.
module line_raster_engine #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 8,
  parameter int FB_W    = 256,
  parameter int FB_H    = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_W-1:0]     cmd_x0,
  input  logic [COORD_W-1:0]     cmd_y0,
  input  logic [COORD_W-1:0]     cmd_x1,
  input  logic [COORD_W-1:0]     cmd_y1,
  input  logic [COLOR_W-1:0]     cmd_color,
  output logic                   px_valid,
  input  logic                   px_ready,
  output logic [2*COORD_W-1:0]   px_addr,
  output logic [COLOR_W-1:0]     px_data,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             state_dbg
);

  localparam int DW  = COORD_W + 1;
  localparam int EW  = COORD_W + 2;
  localparam int E2W = COORD_W + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and payload holds while valid && !ready.

  logic [1:0]          state_q, state_d;
  logic [COORD_W-1:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic [DW-1:0]       dx_q, dx_d, dy_q, dy_d;
  logic                sx_q, sx_d, sy_q, sy_d;
  logic signed [EW-1:0] err_q, err_d;

  logic                 in_fb;
  logic                 advance;
  logic                 at_end;
  logic signed [E2W-1:0] e2;
  logic                 step_x, step_y;
  logic signed [EW-1:0]  dx_e, dy_e, sub_x, add_y;

`ifdef LRE_CLIP_EN
  assign in_fb = (32'(cur_x_q) < FB_W) && (32'(cur_y_q) < FB_H);
`else
  localparam int unused_fb_dims = FB_W + FB_H;
  assign in_fb = 1'b1;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign px_valid  = (state_q == S_DRAW) && in_fb;
  assign px_addr   = {cur_y_q, cur_x_q};
  assign px_data   = color_q;
  assign state_dbg = state_q;

  // Clipped pixels step immediately; visible ones wait for the framebuffer.
  assign advance = (state_q == S_DRAW) && (px_ready || !in_fb);
  assign at_end  = (cur_x_q == x1_q) && (cur_y_q == y1_q);

  assign dx_e   = {1'b0, dx_q};
  assign dy_e   = {1'b0, dy_q};
  assign e2     = {err_q, 1'b0};
  assign step_x = (e2 >= -$signed({2'b00, dy_q}));
  assign step_y = (e2 <= $signed({2'b00, dx_q}));
  assign sub_x  = step_x ? dy_e : '0;
  assign add_y  = step_y ? dx_e : '0;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          x1_d    = cmd_x1;
          y1_d    = cmd_y1;
          color_d = cmd_color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d    = (x1_q >= x0_q) ? {1'b0, x1_q - x0_q} : {1'b0, x0_q - x1_q};
        dy_d    = (y1_q >= y0_q) ? {1'b0, y1_q - y0_q} : {1'b0, y0_q - y1_q};
        sx_d    = (x0_q < x1_q);
        sy_d    = (y0_q < y1_q);
        err_d   = $signed({1'b0, dx_d}) - $signed({1'b0, dy_d});
        cur_x_d = x0_q;
        cur_y_d = y0_q;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (advance) begin
          if (at_end) begin
            state_d = S_DONE;
          end else begin
            // Both axis updates read the pre-update error term.
            err_d = err_q - sub_x + add_y;
            if (step_x) cur_x_d = sx_q ? cur_x_q + COORD_W'(1) : cur_x_q - COORD_W'(1);
            if (step_y) cur_y_d = sy_q ? cur_y_q + COORD_W'(1) : cur_y_q - COORD_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// Bench for line_raster_engine: directed and random lines against a reference pixel list.
module tb_line_raster_engine;
  localparam int COORD_W = 8;
  localparam int COLOR_W = 8;
  localparam int W       = 2*COORD_W + COLOR_W;
`ifdef LRE_CLIP_EN
  localparam int FB_W = 200;
`else
  localparam int FB_W = 256;
`endif
  localparam int FB_H = 256;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [COORD_W-1:0]   cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [COLOR_W-1:0]   cmd_color = '0;
  logic                 px_valid;
  logic                 px_ready = 1'b0;
  logic [2*COORD_W-1:0] px_addr;
  logic [COLOR_W-1:0]   px_data;
  logic                 busy, done;
  logic [1:0]           state_dbg;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  line_raster_engine #(.COORD_W(COORD_W), .COLOR_W(COLOR_W), .FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr), .px_data(px_data),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: textbook integer Bresenham, emitting the visible pixels in order.
  task automatic model(input int x0, input int y0, input int x1, input int y1, input int col);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_q.delete();
    dx = iabs(x1 - x0);
    dy = iabs(y1 - y0);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx - dy;
    x = x0;
    y = y0;
    forever begin
      if (x < FB_W && y < FB_H) exp_q.push_back({8'(col), 8'(y), 8'(x)});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx)  begin err += dx; y += sy; end
    end
  endtask

  // Driver + per-cycle scoreboard for one line command.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int col, input int rdy_pct, input int stall_idx);
    int n_exp, hs_cnt, cyc, stall_left, n_pix;
    bit hs_prev, got_done, stalled, stall_used;
    logic [2*COORD_W-1:0] hold_addr;
    logic [W-1:0] exp;
    model(x0, y0, x1, y1, col);
    n_exp = exp_q.size();
    n_pix = ((iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0)) + 1;
    hs_cnt = 0; cyc = 0; stall_left = 0;
    hs_prev = 0; got_done = 0; stalled = 0; stall_used = 0;
    hold_addr = '0;
    @(negedge clk);
    check_eq("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_x0 = 8'(x0); cmd_y0 = 8'(y0); cmd_x1 = 8'(x1); cmd_y1 = 8'(y1);
    cmd_color = 8'(col);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x0 = 8'($urandom); cmd_y0 = 8'($urandom);
    cmd_x1 = 8'($urandom); cmd_y1 = 8'($urandom); cmd_color = 8'($urandom);
    check_eq("setup_flags", {29'd0, busy, px_valid, cmd_ready}, 32'b100);
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      if (cyc == 0 && x0 < FB_W && y0 < FB_H) check_eq("first_px_valid_t2", 32'(px_valid), 1);
      check_eq("cmd_ready_busy", 32'(cmd_ready), 0);
      if (done) begin
        check_eq("done_after_last_hs", 32'(hs_prev), 1);
        check_eq("exp_q_drained", 32'(exp_q.size()), 0);
        check_eq("busy_in_done", 32'(busy), 1);
        if (rdy_pct == 100 && stall_idx < 0) check_eq("done_cycle", 32'(cyc), 32'(n_pix));
        got_done = 1;
      end else begin
        if (stalled) check_eq("hold_addr", 32'(px_addr), 32'(hold_addr));
        hs_prev = 0;
        if (!stall_used && hs_cnt == stall_idx && px_valid) begin
          stall_left = 3;
          stall_used = 1;
        end
        if (stall_left > 0) begin
          px_ready = 1'b0;
          stall_left--;
        end else begin
          px_ready = ($urandom_range(99) < rdy_pct);
        end
        if (px_valid && px_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_pixel", 32'(px_addr), 32'hFFFF_FFFF);
          end else begin
            exp = exp_q.pop_front();
            check_eq("px_addr", 32'(px_addr), 32'(exp[2*COORD_W-1:0]));
            check_eq("px_data", 32'(px_data), 32'(exp[W-1:2*COORD_W]));
          end
          hs_cnt++;
          hs_prev = 1;
        end
        stalled = px_valid && !px_ready;
        hold_addr = px_addr;
      end
      cyc++;
    end
    if (!got_done) check_eq("done_timeout", 0, 1);
`ifdef LRE_CLIP_EN
    check_eq("hs_count", 32'(hs_cnt), 32'(n_exp));
`else
    check_eq("hs_count", 32'(hs_cnt), 32'(n_pix));
`endif
    @(negedge clk);
    check_eq("idle_after_done", {29'd0, cmd_ready, busy, done}, 32'b100);
    px_ready = 1'b0;
  endtask

  initial begin
    int rx0, ry0, rx1, ry1, span;
    repeat (3) @(negedge clk);
    check_eq("reset_flags", {28'd0, cmd_ready, px_valid, busy, done}, 32'b1000);
    check_eq("reset_addr", 32'(px_addr), 0);
    check_eq("reset_data", 32'(px_data), 0);
    rst = 1'b0;

    run_line(0, 0, 3, 0, 8'hAA, 100, -1);   // horizontal
    run_line(0, 0, 1, 3, 8'h55, 100, -1);   // steep
    run_line(3, 3, 0, 0, 8'h3C, 100, -1);   // reverse diagonal
    run_line(0, 0, 3, 0, 8'h81, 100, 1);    // stall while 0x0001 presented
    run_line(5, 7, 5, 7, 8'h07, 100, -1);   // zero length

    // Reset at the second pixel of a long diagonal.
    @(negedge clk);
    cmd_x0 = 8'd0; cmd_y0 = 8'd0; cmd_x1 = 8'd9; cmd_y1 = 8'd9; cmd_color = 8'h99;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    px_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_line_px1", 32'(px_addr), 32'h0000);
    @(negedge clk);
    check_eq("rst_line_px2", 32'(px_addr), 32'h0101);
    rst = 1'b1;
    @(negedge clk);
    check_eq("after_rst_flags", {28'd0, cmd_ready, px_valid, busy, done}, 32'b1000);
    rst = 1'b0;
    px_ready = 1'b0;
    @(negedge clk);
    check_eq("no_done_after_rst", 32'(done), 0);
    run_line(2, 0, 2, 1, 8'h42, 100, -1);

`ifdef LRE_CLIP_EN
    run_line(198, 0, 201, 0, 8'h0C, 100, -1);
    run_line(210, 5, 230, 40, 8'h0D, 100, -1);
`endif

    for (int i = 0; i < 24; i++) begin
      span = (i < 12) ? 15 : 255;
      rx0 = $urandom_range(span); ry0 = $urandom_range(span);
      rx1 = $urandom_range(span); ry1 = $urandom_range(span);
      run_line(rx0, ry0, rx1, ry1, $urandom_range(255), $urandom_range(30, 100),
               (i % 3 == 0) ? $urandom_range(3) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_raster_engine.md
Name: line_raster_engine

Overview:
- Parametrised Bresenham line rasteriser: accepts one line command (two endpoints + colour) through a valid/ready handshake and streams one framebuffer write per pixel through a valid/ready pixel port.
- Covers all octants and both endpoints, applies output backpressure, and signals completion.
- Sits between the AXI-Lite command registers and the framebuffer write port of the wireframe pipeline.

Parameters:
- COORD_W, 8, bit width of each unsigned coordinate.
- COLOR_W, 8, bit width of pixel colour.
- FB_W, 256, framebuffer width in pixels; used only when LRE_CLIP_EN is defined.
- FB_H, 256, framebuffer height in pixels; used only when LRE_CLIP_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  COORD_W each  unsigned endpoints
- cmd_color  in  COLOR_W  line colour
- px_valid  out  1  pixel write valid
- px_ready  in  1  framebuffer accepts pixel
- px_addr  out  2*COORD_W  pixel address, {y, x}
- px_data  out  COLOR_W  pixel colour
- busy  out  1  high from command acceptance until done
- done  out  1  single-cycle pulse after the last pixel handshake

Behaviour:
- Reset values:
  - state=IDLE, cmd_ready=1, px_valid=0, busy=0, done=0
  - px_addr=0, px_data=0
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch endpoints and colour, then go to SETUP. Inputs are ignored after the accept cycle.
  - SETUP (1 cycle):
    - dx=|x1-x0| and dy=|y1-y0|, computed at COORD_W+1 bits.
    - sx=+1 if x0<x1, else -1; sy likewise.
    - err=dx-dy, signed COORD_W+2 bits.
    - cur=(x0,y0). Then go to DRAW.
  - DRAW:
    - px_valid=1; px_addr={cur_y,cur_x}; px_data=latched colour.
    - On px_valid&px_ready:
      - If cur==(x1,y1), go to DONE.
      - Otherwise e2=2*err (COORD_W+3 bits).
      - If e2>=-dy: err-=dy, cur_x+=sx.
      - If e2<=dx: err+=dx, cur_y+=sy.
      - Both updates may apply in the same cycle and use the pre-update err.
  - DONE: done=1 for one cycle, busy=0 next, return to IDLE.
- cmd_ready=0 in SETUP/DRAW/DONE; busy=1 in those same states.
- Latency:
  - Command accepted in cycle T gives first px_valid in T+2.
  - With px_ready held high, one pixel per cycle.
  - Pixel count is max(dx,dy)+1.
  - done is asserted the cycle after the final pixel handshake.
- Backpressure: while px_valid&!px_ready, px_addr, px_data and internal state hold stable.
- Zero-length line (x0=x1, y0=y1): exactly one pixel, then done.
- Coordinates never wrap: endpoints are in range and stepping stops at (x1,y1).
- Reset asserted mid-line: next cycle is IDLE, px_valid=0, no done pulse, and the partial line is abandoned.
- cmd_valid held high through DONE does not start a new command until the IDLE cycle.

Optional Feature:
- Macro LRE_CLIP_EN.
- Defined:
  - In DRAW, a pixel with cur_x>=FB_W or cur_y>=FB_H gets px_valid=0. The stepper still advances one step per cycle without waiting for px_ready.
  - A line entirely outside the framebuffer emits no pixels but still pulses done.
- Undefined:
  - Every rasterised pixel is emitted regardless of FB_W/FB_H, and no comparators are built.

Test Plan:
- Horizontal (0,0)->(3,0), colour 0xAA, px_ready=1 → px_addr 0x0000,0x0001,0x0002,0x0003 on consecutive cycles starting T+2; px_data=0xAA; done pulse at T+6.
- Steep (0,0)->(1,3) → addresses 0x0000,0x0100,0x0201,0x0301, then done.
- Reverse diagonal (3,3)->(0,0) → 0x0303,0x0202,0x0101,0x0000, with both endpoints emitted.
- Backpressure on (0,0)->(3,0): px_ready low for 3 cycles while 0x0001 is presented → px_addr holds 0x0001 stable, no pixel is skipped or duplicated, total 4 handshakes.
- Zero-length (5,7)->(5,7) → single pixel 0x0705, done; cmd_ready=0 through DONE and returns to 1 in the following IDLE cycle.
- Reset at the 2nd pixel of (0,0)->(9,9) → px_valid=0 next cycle, no done pulse; new command (2,0)->(2,1) then yields 0x0002,0x0102.
- LRE_CLIP_EN with FB_W=200: (198,0)->(201,0) → only 0x00C6,0x00C7 emitted, done still pulses.
